// File: rtl/sifh_pkg.sv
// Shared definitions for the SiFH dToF acquisition front end: default sizing,
// the no-hit code, the sequencer state encoding and the TOF code type.
package sifh_pkg;

  localparam int NP        = 10;
  localparam int PIXEL_NUM = 6;
  localparam int SHOT_NUM  = 16;
  localparam int WIN_CYC   = 64;
  localparam int DRAIN_CYC = 4;

  localparam logic [NP-1:0] NO_HIT = {NP{1'b1}};

  typedef logic [NP-1:0] tof_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    WINDOW = 3'd2,
    DRAIN  = 3'd3,
    OUT    = 3'd4
  } state_e;

endpackage

// File: rtl/shot_window_capture.sv
// Per-pixel first-hit capture bank with NO_HIT clamping. bank/taken present the
// contents including this cycle's accepted hits, so a closing-cycle hit is visible.
module shot_window_capture #(
  parameter int NP        = sifh_pkg::NP,
  parameter int PIXEL_NUM = sifh_pkg::PIXEL_NUM
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    open,
  input  logic                    close,
  input  logic                    clear,
  input  logic [PIXEL_NUM-1:0]    hit_vld,
  input  logic [PIXEL_NUM*NP-1:0] hit_tof,
  output logic [PIXEL_NUM*NP-1:0] bank,
  output logic [PIXEL_NUM-1:0]    taken
);

  localparam logic [NP-1:0] NO_HIT_L  = {NP{1'b1}};
  localparam logic [NP-1:0] MAX_HIT_L = {{(NP-1){1'b1}}, 1'b0};

  logic [PIXEL_NUM*NP-1:0] tof_q, tof_d;
  logic [PIXEL_NUM-1:0]    taken_q, taken_d;
  logic [NP-1:0]           code_s;

  always_comb begin
    bank    = tof_q;
    taken   = taken_q;
    code_s  = '0;
    for (int p = 0; p < PIXEL_NUM; p++) begin
      code_s = hit_tof[p*NP +: NP];
      if (code_s == NO_HIT_L) begin
        code_s = MAX_HIT_L;
      end else begin
        code_s = hit_tof[p*NP +: NP];
      end
      if (open && hit_vld[p] && !taken_q[p]) begin
        bank[p*NP +: NP] = code_s;
        taken[p]         = 1'b1;
      end else begin
        bank[p*NP +: NP] = tof_q[p*NP +: NP];
        taken[p]         = taken_q[p];
      end
    end
    // The bank empties once its contents have been handed to the issue side.
    if (clear || close) begin
      tof_d   = '0;
      taken_d = '0;
    end else begin
      tof_d   = bank;
      taken_d = taken;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      tof_q   <= '0;
      taken_q <= '0;
    end else begin
      tof_q   <= tof_d;
      taken_q <= taken_d;
    end
  end

endmodule

// File: rtl/hist_acq_sequencer.sv
// Acquisition sequencer: opens one TOF window per shot, streams captured codes to
// the histogram builder, then drains it, latches peaks and clears the histogram.
module hist_acq_sequencer #(
  parameter int NP        = sifh_pkg::NP,
  parameter int PIXEL_NUM = sifh_pkg::PIXEL_NUM,
  parameter int SHOT_NUM  = sifh_pkg::SHOT_NUM,
  parameter int WIN_CYC   = sifh_pkg::WIN_CYC,
  parameter int DRAIN_CYC = sifh_pkg::DRAIN_CYC
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    start,
  input  logic                    shot_start,
  input  logic [PIXEL_NUM-1:0]    hit_vld,
  input  logic [PIXEL_NUM*NP-1:0] hit_tof,
  output logic                    hb_wrEn,
  output logic [NP-1:0]           hb_data,
  output logic                    hb_clr,
  input  logic [PIXEL_NUM*NP-1:0] peak_in,
  output logic [PIXEL_NUM*NP-1:0] peak_out,
  output logic                    frame_vld,
  output logic                    busy,
  output logic                    overrun
);

  import sifh_pkg::*;

  localparam int WW = $clog2(WIN_CYC + 1);
  localparam int SW = $clog2(SHOT_NUM + 1);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam int IW = $clog2(PIXEL_NUM + 1);

  localparam logic [WW-1:0] WIN_LAST   = WW'(WIN_CYC - 1);
  localparam logic [SW-1:0] SHOT_LAST  = SW'(SHOT_NUM - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(PIXEL_NUM - 1);
  localparam logic [NP-1:0] NO_HIT_L   = {NP{1'b1}};
  localparam logic          MULTI_PIX  = (PIXEL_NUM > 1) ? 1'b1 : 1'b0;

  state_e                  state_q, state_d;
  logic [WW-1:0]           win_cnt_q, win_cnt_d;
  logic [SW-1:0]           shot_cnt_q, shot_cnt_d;
  logic [DW-1:0]           drain_cnt_q, drain_cnt_d;
  logic                    overrun_q, overrun_d;
  logic                    frame_vld_q, frame_vld_d;
  logic                    hb_clr_q, hb_clr_d;
  logic                    busy_q, busy_d;
  logic [PIXEL_NUM*NP-1:0] peak_out_q, peak_out_d;

  logic [PIXEL_NUM*NP-1:0] issue_bank_q, issue_bank_d;
  logic [IW-1:0]           issue_idx_q, issue_idx_d;
  logic                    issue_act_q, issue_act_d;
  logic                    hb_wr_en_q, hb_wr_en_d;
  logic [NP-1:0]           hb_data_q, hb_data_d;

  logic                    win_close_s;
  logic [PIXEL_NUM*NP-1:0] cap_bank_s;
  logic [PIXEL_NUM-1:0]    cap_taken_s;
  logic [PIXEL_NUM*NP-1:0] copy_s;

  shot_window_capture #(
    .NP        (NP),
    .PIXEL_NUM (PIXEL_NUM)
  ) u_capture (
    .clk     (clk),
    .res     (res),
    .open    (state_q == WINDOW),
    .close   (win_close_s),
    .clear   (state_q == IDLE),
    .hit_vld (hit_vld),
    .hit_tof (hit_tof),
    .bank    (cap_bank_s),
    .taken   (cap_taken_s)
  );

  // Sequencer next-state, counters and registered frame outputs.
  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    shot_cnt_d  = shot_cnt_q;
    drain_cnt_d = drain_cnt_q;
    overrun_d   = overrun_q;
    peak_out_d  = peak_out_q;
    frame_vld_d = 1'b0;
    hb_clr_d    = 1'b0;
    win_close_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ARMED;
          shot_cnt_d = '0;
          overrun_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        if (shot_start) begin
          state_d   = WINDOW;
          win_cnt_d = '0;
        end else begin
          state_d = ARMED;
        end
      end
      WINDOW: begin
        if (shot_start) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        if (win_cnt_q == WIN_LAST) begin
          win_close_s = 1'b1;
          shot_cnt_d  = shot_cnt_q + SW'(1);
          if (shot_cnt_q == SHOT_LAST) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end else begin
            state_d = ARMED;
          end
        end else begin
          win_cnt_d = win_cnt_q + WW'(1);
        end
      end
      DRAIN: begin
        if (shot_start) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        // The drain count only starts once the last issue word has gone out.
        if (hb_wr_en_q) begin
          drain_cnt_d = '0;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d     = OUT;
          frame_vld_d = 1'b1;
          hb_clr_d    = 1'b1;
          peak_out_d  = peak_in;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      OUT: begin
        if (shot_start) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Snapshot of the closing window with NO_HIT filled into untaken pixels.
  always_comb begin
    copy_s = '0;
    for (int p = 0; p < PIXEL_NUM; p++) begin
      if (cap_taken_s[p]) begin
        copy_s[p*NP +: NP] = cap_bank_s[p*NP +: NP];
      end else begin
        copy_s[p*NP +: NP] = NO_HIT_L;
      end
    end
  end

  // Issue engine: pixel 0 leaves on the close edge, the rest follow back-to-back.
  always_comb begin
    issue_bank_d = issue_bank_q;
    issue_idx_d  = issue_idx_q;
    issue_act_d  = issue_act_q;
    hb_wr_en_d   = 1'b0;
    hb_data_d    = '0;
    if (win_close_s) begin
      issue_bank_d = copy_s;
      hb_wr_en_d   = 1'b1;
      hb_data_d    = copy_s[NP-1:0];
      issue_idx_d  = IW'(1);
      issue_act_d  = MULTI_PIX;
    end else if (issue_act_q) begin
      hb_wr_en_d = 1'b1;
      hb_data_d  = issue_bank_q[int'(issue_idx_q)*NP +: NP];
      if (issue_idx_q == IDX_LAST) begin
        issue_act_d = 1'b0;
        issue_idx_d = '0;
      end else begin
        issue_idx_d = issue_idx_q + IW'(1);
      end
    end else begin
      issue_act_d = 1'b0;
    end
  end

  // Single state/output register bank.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= IDLE;
      win_cnt_q    <= '0;
      shot_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      overrun_q    <= 1'b0;
      frame_vld_q  <= 1'b0;
      hb_clr_q     <= 1'b0;
      busy_q       <= 1'b0;
      peak_out_q   <= '0;
      issue_bank_q <= '0;
      issue_idx_q  <= '0;
      issue_act_q  <= 1'b0;
      hb_wr_en_q   <= 1'b0;
      hb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      shot_cnt_q   <= shot_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      overrun_q    <= overrun_d;
      frame_vld_q  <= frame_vld_d;
      hb_clr_q     <= hb_clr_d;
      busy_q       <= busy_d;
      peak_out_q   <= peak_out_d;
      issue_bank_q <= issue_bank_d;
      issue_idx_q  <= issue_idx_d;
      issue_act_q  <= issue_act_d;
      hb_wr_en_q   <= hb_wr_en_d;
      hb_data_q    <= hb_data_d;
    end
  end

  assign hb_wrEn   = hb_wr_en_q;
  assign hb_data   = hb_data_q;
  assign hb_clr    = hb_clr_q;
  assign peak_out  = peak_out_q;
  assign frame_vld = frame_vld_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_hist_acq_sequencer.sv
// Bench for hist_acq_sequencer: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a timestamp-based reference model.
module tb_hist_acq_sequencer;

  localparam int NP     = 10;
  localparam int P      = 3;
  localparam int S      = 2;
  localparam int W      = 8;
  localparam int D      = 4;
  localparam int NO_HIT = (1 << NP) - 1;

  logic            clk = 1'b0;
  logic            res, start, shot_start;
  logic [P-1:0]    hit_vld;
  logic [P*NP-1:0] hit_tof, peak_in, peak_out;
  logic            hb_wrEn, hb_clr, frame_vld, busy, overrun;
  logic [NP-1:0]   hb_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hist_acq_sequencer #(
    .NP(NP), .PIXEL_NUM(P), .SHOT_NUM(S), .WIN_CYC(W), .DRAIN_CYC(D)
  ) dut (
    .clk(clk), .res(res), .start(start), .shot_start(shot_start),
    .hit_vld(hit_vld), .hit_tof(hit_tof),
    .hb_wrEn(hb_wrEn), .hb_data(hb_data), .hb_clr(hb_clr),
    .peak_in(peak_in), .peak_out(peak_out), .frame_vld(frame_vld),
    .busy(busy), .overrun(overrun)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: an acquisition is a list of timestamped windows; expected
  // builder writes and frame pulses are scheduled into a ring indexed by cycle.
  int              m_cyc = 0;
  bit              chk_en = 1'b0;
  bit              m_acq = 1'b0;
  bit              m_ovr = 1'b0;
  int              m_shots, m_wb, m_we, m_out;
  logic [P*NP-1:0] m_peak = '0;
  int              m_cap[P];
  bit              m_tk[P];
  bit              r_wr[256];
  int              r_data[256];
  bit              r_frm[256];

  initial begin
    int c, v, idx;
    forever begin
      @(posedge clk);
      c = m_cyc;
      if (res) begin
        m_acq  = 1'b0;
        m_ovr  = 1'b0;
        m_peak = '0;
        for (int i = 0; i < 256; i++) begin
          r_wr[i] = 1'b0; r_data[i] = 0; r_frm[i] = 1'b0;
        end
        for (int p = 0; p < P; p++) m_tk[p] = 1'b0;
        chk_en = 1'b1;
      end else if (!m_acq) begin
        if (start) begin
          m_acq = 1'b1; m_shots = 0; m_ovr = 1'b0; m_wb = 0; m_we = -1;
        end
      end else if (c >= m_wb && c <= m_we) begin
        if (shot_start) m_ovr = 1'b1;
        for (int p = 0; p < P; p++) begin
          if (hit_vld[p] && !m_tk[p]) begin
            m_tk[p]  = 1'b1;
            v        = int'(hit_tof[p*NP +: NP]);
            m_cap[p] = (v == NO_HIT) ? NO_HIT - 1 : v;
          end
        end
        if (c == m_we) begin
          for (int p = 0; p < P; p++) begin
            idx         = (c + 1 + p) % 256;
            r_wr[idx]   = 1'b1;
            r_data[idx] = m_tk[p] ? m_cap[p] : NO_HIT;
            m_tk[p]     = 1'b0;
          end
          m_shots++;
          if (m_shots == S) begin
            m_out = c + P + D + 1;
            r_frm[m_out % 256] = 1'b1;
          end
        end
      end else if (m_shots < S) begin
        if (shot_start) begin
          m_wb = c + 1;
          m_we = c + W;
        end
      end else begin
        if (shot_start) m_ovr = 1'b1;
        if (c == m_out - 1) m_peak = peak_in;
        if (c == m_out) m_acq = 1'b0;
      end
      m_cyc = c + 1;
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  initial begin
    int idx;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        idx = m_cyc % 256;
        check("hb_wrEn", int'(hb_wrEn), int'(r_wr[idx]));
        if (r_wr[idx]) check("hb_data", int'(hb_data), r_data[idx]);
        check("frame_vld", int'(frame_vld), int'(r_frm[idx]));
        check("hb_clr", int'(hb_clr), int'(r_frm[idx]));
        check("busy", int'(busy), int'(m_acq));
        check("overrun", int'(overrun), int'(m_ovr));
        check("peak_out", int'(peak_out), int'(m_peak));
        r_wr[idx] = 1'b0; r_data[idx] = 0; r_frm[idx] = 1'b0;
      end
    end
  end

  initial begin
    logic [P*NP-1:0] exp_pk;
    int r;
    exp_pk     = {10'h3FF, 10'h155, 10'h0AA};
    res        = 1'b1;
    start      = 1'b0;
    shot_start = 1'b0;
    hit_vld    = '0;
    hit_tof    = '0;
    peak_in    = exp_pk;
    step(3);
    res = 1'b0;
    step(1);
    check("rst_wrEn", int'(hb_wrEn), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_peak", int'(peak_out), 0);

    // Shot 1: p0=108, p2=511, p1 silent.
    start = 1'b1; step(1); start = 1'b0;
    shot_start = 1'b1; step(1); shot_start = 1'b0;          // cycle t+1
    hit_vld = 3'b101; hit_tof = {10'd511, 10'd0, 10'd108};
    step(1); hit_vld = '0; hit_tof = '0;
    step(7);                                                // t+9
    check("s1_w0_en", int'(hb_wrEn), 1);
    check("s1_w0", int'(hb_data), 108);
    step(1);
    check("s1_w1", int'(hb_data), 1023);
    step(1);
    check("s1_w2", int'(hb_data), 511);
    step(1);
    check("s1_end", int'(hb_wrEn), 0);

    // Shot 2: double hit on p0, closing-cycle clamp on p1, early shot, late p2.
    shot_start = 1'b1; step(1); shot_start = 1'b0;          // u+1
    hit_vld = 3'b001; hit_tof = {10'd0, 10'd0, 10'd200};
    step(1);
    hit_tof = {10'd0, 10'd0, 10'd90};
    step(1);                                                // u+3
    hit_vld = '0; shot_start = 1'b1;
    step(1); shot_start = 1'b0;                             // u+4
    check("early_overrun", int'(overrun), 1);
    step(4);                                                // u+8 closing cycle
    hit_vld = 3'b010; hit_tof = {10'd0, 10'd1023, 10'd0};
    step(1);                                                // u+9
    hit_vld = 3'b100; hit_tof = {10'd55, 10'd0, 10'd0};
    check("s2_w0", int'(hb_data), 200);
    step(1);
    hit_vld = '0; hit_tof = '0;
    check("s2_w1", int'(hb_data), 1022);
    step(1);
    check("s2_w2", int'(hb_data), 1023);
    step(5);                                                // u+16
    check("out_frame", int'(frame_vld), 1);
    check("out_clr", int'(hb_clr), 1);
    check("out_peak", int'(peak_out), int'(exp_pk));
    step(1);
    check("post_busy", int'(busy), 0);
    check("post_frame", int'(frame_vld), 0);

    // Reset in the middle of an issue burst, with overrun pending.
    start = 1'b1; step(1); start = 1'b0;
    check("start_clr_ovr", int'(overrun), 0);
    shot_start = 1'b1; step(1); shot_start = 1'b0;
    hit_vld = 3'b111; hit_tof = {10'd7, 10'd8, 10'd9};
    step(1); hit_vld = '0;
    step(1); shot_start = 1'b1; step(1); shot_start = 1'b0;
    step(5);                                                // t+10, mid-issue
    res = 1'b1; step(1); res = 1'b0;
    check("res_wrEn", int'(hb_wrEn), 0);
    check("res_busy", int'(busy), 0);
    check("res_overrun", int'(overrun), 0);

    // start held high: back-to-back shots, one frame, re-arm right after OUT.
    start = 1'b1; step(1);
    shot_start = 1'b1; step(1); shot_start = 1'b0;
    hit_vld = 3'b010; hit_tof = {10'd0, 10'd333, 10'd0};
    step(1); hit_vld = '0;
    step(W - 1);                                            // a+W+1
    shot_start = 1'b1; step(1); shot_start = 1'b0;
    step(15);                                               // OUT
    check("held_out_clr", int'(hb_clr), 1);
    check("held_out_busy", int'(busy), 1);
    step(1);
    check("held_idle_busy", int'(busy), 0);
    check("held_clr_once", int'(hb_clr), 0);
    step(1);
    check("held_rearm", int'(busy), 1);
    start = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      res        = ($urandom_range(0, 499) == 0);
      start      = ($urandom_range(0, 7) == 0);
      shot_start = ($urandom_range(0, 5) == 0);
      for (int p = 0; p < P; p++) begin
        hit_vld[p] = ($urandom_range(0, 3) == 0);
        r = int'($urandom_range(0, 9));
        if (r == 0)      hit_tof[p*NP +: NP] = 10'h3FF;
        else if (r == 1) hit_tof[p*NP +: NP] = 10'h3FE;
        else             hit_tof[p*NP +: NP] = NP'($urandom_range(0, 1023));
      end
      peak_in = (P*NP)'($urandom);
      step(1);
    end
    res = 1'b0; start = 1'b0; shot_start = 1'b0; hit_vld = '0;
    step(40);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hist_acq_sequencer.md
# hist_acq_sequencer

Acquisition sequencer sitting in front of the histogram builder FSM in the SiFH dToF pipeline. It opens one time-of-flight window per laser shot and captures the first hit of every pixel in that window. It then streams the captured TOF codes to the builder in fixed pixel order, one word per cycle. After SHOT_NUM shots it drains the builder, latches the per-pixel peak results, and clears the histogram for the next acquisition.

## Interface
- NP, 10, TOF code width (same as builder data width)
- PIXEL_NUM, 6, pixels served per builder RAM
- SHOT_NUM, 16, shots per acquisition
- WIN_CYC, 64, window length in clk cycles; must be ≥ PIXEL_NUM
- DRAIN_CYC, 4, builder pipeline latency before peaks are valid
- clk  in  1  single clock, all logic rising-edge
- res  in  1  reset, synchronous, active-high
- start  in  1  arm one acquisition (ignored unless IDLE)
- shot_start  in  1  laser-fire pulse, opens a window
- hit_vld  in  PIXEL_NUM  per-pixel hit strobe
- hit_tof  in  PIXEL_NUM*NP  per-pixel TOF code; pixel p at [p*NP +: NP]
- hb_wrEn  out  1  builder write enable
- hb_data  out  NP  builder write data
- hb_clr  out  1  one-cycle histogram clear pulse
- peak_in  in  PIXEL_NUM*NP  builder peak results, same packing
- peak_out  out  PIXEL_NUM*NP  latched peaks
- frame_vld  out  1  one-cycle pulse, peak_out updated
- busy  out  1  high in any state except IDLE
- overrun  out  1  sticky; cleared by res or by start accepted in IDLE

## Operation
- NO_HIT = 2^NP−1. A real hit whose code equals NO_HIT is clamped to 2^NP−2.
- States:
  - IDLE: start → ARMED; shot_cnt cleared; overrun cleared.
  - ARMED: shot_start → WINDOW; win_cnt = 0.
  - WINDOW: counts WIN_CYC cycles, then closes. On close, shot_cnt++. If shot_cnt has reached SHOT_NUM → DRAIN, else → ARMED.
  - DRAIN: waits until the issue engine is idle, then counts DRAIN_CYC cycles, then → OUT.
  - OUT: one cycle; peak_out ← peak_in, frame_vld = 1, hb_clr = 1; → IDLE.
- Capture bank:
  - One NP-bit register plus one taken flag per pixel.
  - In WINDOW, the first hit_vld[p] loads clamped hit_tof[p] and sets taken. Later hits in the same window are ignored.
  - A hit in the closing cycle (win_cnt = WIN_CYC−1) is captured.
  - Hits outside WINDOW are ignored.
- Double buffer and issue engine:
  - On window close, the capture bank is copied to the issue bank; untaken pixels get NO_HIT. The capture bank then clears.
  - The issue engine emits pixels 0..PIXEL_NUM−1 on hb_data with hb_wrEn high, one per cycle.
  - Issue runs concurrently with the next ARMED/WINDOW.
- Overrun conditions (set overrun, no other effect):
  - shot_start while in WINDOW: pulse ignored, window not restarted.
  - shot_start in DRAIN or OUT: pulse ignored.
- start outside IDLE is ignored.
- start and shot_start in the same IDLE cycle: start accepted, shot_start ignored.
- res mid-acquisition: all state, counters and banks clear to reset values. No hb_clr is generated; upstream resets the builder with the same res.

## Timing
- Reset values: hb_wrEn 0, hb_data 0, hb_clr 0, peak_out 0, frame_vld 0, busy 0, overrun 0. State is IDLE, all counters 0.
- Window length: shot_start sampled at cycle t → capture open during cycles t+1 .. t+WIN_CYC.
- Issue latency: hb_wrEn high in cycles t+WIN_CYC+1 .. t+WIN_CYC+PIXEL_NUM, pixel p at t+WIN_CYC+1+p.
- hb_wrEn is never high in more than PIXEL_NUM consecutive cycles per window. Gaps between words of one window are not allowed.
- WIN_CYC ≥ PIXEL_NUM guarantees each issue burst completes before the next copy.
- Final window:
  - Issue ends at cycle e.
  - DRAIN counts cycles e+1 .. e+DRAIN_CYC.
  - OUT at cycle e+DRAIN_CYC+1, where frame_vld and hb_clr are high.
  - busy falls the following cycle.

## Structure
- Shared package sifh_pkg holds:
  - NP, PIXEL_NUM, SHOT_NUM, WIN_CYC, DRAIN_CYC defaults;
  - NO_HIT constant;
  - state enum (IDLE, ARMED, WINDOW, DRAIN, OUT);
  - a tof_t typedef of NP bits.
- One sub-module, shot_window_capture, holds the per-pixel first-hit capture bank plus clamp. Inputs: open, close, clear. Output: packed bank and taken vector.
- The sequencer FSM, issue engine and peak latch live in the top module.

## Test plan
- Single shot, PIXEL_NUM=3, SHOT_NUM=1, WIN_CYC=8, DRAIN_CYC=4. Hits p0=108, p2=511, p1 none → hb_data 108, 1023, 511 in 3 consecutive hb_wrEn cycles at t+9..t+11; frame_vld at t+16, where the peak_in pattern 0x3FF_155_0AA appears on peak_out.
- Double hit: p0 hits 200 then 90 in the same window → 200 issued. A p1 hit of 1023 → issued as 1022.
- Back-to-back shots: shot_start exactly WIN_CYC+1 cycles apart, SHOT_NUM=2 → two contiguous 3-word bursts, overrun stays 0, exactly one frame_vld.
- Early shot_start 3 cycles into a window → overrun=1, window end unchanged, shot_cnt counts one shot.
- res asserted mid-issue → next cycle hb_wrEn=0, busy=0, overrun=0. A fresh start produces a full acquisition with no stale data.
- start held high through an acquisition → only one acquisition. Re-arm happens the cycle after OUT; hb_clr is exactly one cycle.
